// File: rtl/prbs5_checker.sv
// prbs5_checker: self-synchronising checker for a 5-bit PRBS stream (x^5+x^3+1).
// HUNT fills the local LFSR from the line, VERIFY counts consecutive correct
// predictions, and LOCKED flywheels the local LFSR while counting bit errors.
// Lock is dropped when ERR_THRESH errors land inside one 31-bit window.
// Optional feature macro: PRBS_STUCK_DET_EN (all-zero stream detection).
module prbs5_checker #(
  parameter int LOCK_CNT   = 8,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             stuck
);

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [4:0]       r_s, w_s_nxt;
  logic [2:0]       r_fill, w_fill_nxt;
  logic [7:0]       r_match_cnt, w_match_cnt_nxt;
  logic [4:0]       r_win_cnt, w_win_cnt_nxt;
  logic [4:0]       r_win_err, w_win_err_nxt;
  logic             r_err_pulse, w_err_pulse_nxt;
  logic [CNT_W-1:0] r_err_count, w_err_count_nxt;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_pred;
  logic             w_win_wrap;
  logic             w_s_zero;

  assign w_pred     = r_s[4] ^ r_s[2];
  assign w_win_wrap = (r_win_cnt == 5'd30);
  // clear wins over the old value, so a same-cycle error then counts from zero
  assign w_cnt_base = clear ? '0 : r_err_count;

`ifdef PRBS_STUCK_DET_EN
  logic r_stuck;

  assign w_s_zero = (r_s == 5'd0);
  assign stuck    = r_stuck;

  // Stuck flag: set by an all-zero match in VERIFY, cleared by any valid one bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stuck <= 1'b0;
    end else if (din_valid) begin
      if (din)
        r_stuck <= 1'b0;
      else if (r_state == ST_VERIFY && w_s_zero)
        r_stuck <= 1'b1;
    end
  end
`else
  assign w_s_zero = 1'b0;
  assign stuck    = 1'b0;
`endif

  assign locked    = (r_state == ST_LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

  // Next-state and datapath: hold everything unless a valid bit arrives
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    w_state_nxt     = r_state;
    w_s_nxt         = r_s;
    w_fill_nxt      = r_fill;
    w_match_cnt_nxt = r_match_cnt;
    w_win_cnt_nxt   = r_win_cnt;
    w_win_err_nxt   = r_win_err;
    w_err_pulse_nxt = 1'b0;
    w_err_count_nxt = w_cnt_base;

    if (din_valid) begin
      unique case (r_state)
        ST_HUNT: begin
          w_s_nxt = {r_s[3:0], din};
          if (r_fill == 3'd4) begin
            w_fill_nxt      = 3'd0;
            w_match_cnt_nxt = 8'd0;
            w_state_nxt     = ST_VERIFY;
          end else begin
            w_fill_nxt = r_fill + 3'd1;
          end
        end

        ST_VERIFY: begin
          w_s_nxt = {r_s[3:0], din};
          if (w_s_zero && !din) begin
            w_match_cnt_nxt = 8'd0;
          end else if (din == w_pred) begin
            if (r_match_cnt + 8'd1 == 8'(LOCK_CNT)) begin
              w_match_cnt_nxt = 8'd0;
              w_win_cnt_nxt   = 5'd0;
              w_win_err_nxt   = 5'd0;
              w_state_nxt     = ST_LOCKED;
            end else begin
              w_match_cnt_nxt = r_match_cnt + 8'd1;
            end
          end else begin
            w_match_cnt_nxt = 8'd0;
          end
        end

        ST_LOCKED: begin
          if (w_s_zero) begin
            // flywheel collapsed onto the all-zero fixed point: start over
            w_fill_nxt  = 3'd0;
            w_state_nxt = ST_HUNT;
          end else begin
            w_win_cnt_nxt = w_win_wrap ? 5'd0 : r_win_cnt + 5'd1;
            w_s_nxt       = {r_s[3:0], w_pred};
            if (w_win_wrap)
              w_win_err_nxt = 5'd0;
            if (din != w_pred) begin
              w_err_pulse_nxt = 1'b1;
              w_err_count_nxt = (w_cnt_base == '1) ? w_cnt_base : w_cnt_base + 1'b1;
              if (r_win_err + 5'd1 == 5'(ERR_THRESH)) begin
                // loss of lock beats the window wrap on the same bit
                w_s_nxt       = r_s;
                w_win_err_nxt = 5'd0;
                w_fill_nxt    = 3'd0;
                w_state_nxt   = ST_HUNT;
              end else if (!w_win_wrap) begin
                w_win_err_nxt = r_win_err + 5'd1;
              end
            end
          end
        end

        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_HUNT;
      r_s         <= 5'd0;
      r_fill      <= 3'd0;
      r_match_cnt <= 8'd0;
      r_win_cnt   <= 5'd0;
      r_win_err   <= 5'd0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_nxt;
      r_s         <= w_s_nxt;
      r_fill      <= w_fill_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_win_cnt   <= w_win_cnt_nxt;
      r_win_err   <= w_win_err_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

endmodule

// File: tb/tb_prbs5_checker.sv
// tb_prbs5_checker: directed and randomized checks of prbs5_checker against a
// bit-history reference model; a second CNT_W=4 instance covers saturation.
module tb_prbs5_checker;

  localparam int LOCK   = 8;
  localparam int THRESH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic        clear = 1'b0;
  logic        locked, err_pulse, stuck;
  logic [15:0] err_count;
  logic        s_locked, s_err_pulse, s_stuck;
  logic [3:0]  s_err_count;

  always #5 clk = ~clk;

  prbs5_checker #(.LOCK_CNT(LOCK), .ERR_THRESH(THRESH), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .stuck(stuck)
  );

  prbs5_checker #(.LOCK_CNT(LOCK), .ERR_THRESH(THRESH), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clear(clear),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count), .stuck(s_stuck)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit g [0:1199];   // golden stream, g[1] is the first transmitted bit

  // reference model: mode 0=hunt 1=verify 2=locked; history of the last 5 bits
  int m_mode, m_fill, m_run, m_pos, m_werr, m_cnt, m_cnt_sat;
  bit m_pulse, m_stuck;
  bit m_hist [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_run = 0; m_pos = 0; m_werr = 0;
    m_cnt = 0; m_cnt_sat = 0; m_pulse = 0; m_stuck = 0;
    m_hist = '{0, 0, 0, 0, 0};
  endtask

  task automatic hist_push(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic model_step(input bit v, input bit d, input bit c);
    bit p, z, skip, wrap;
    m_pulse = 0;
    if (c) begin m_cnt = 0; m_cnt_sat = 0; end
    if (v) begin
      p    = m_hist[0] ^ m_hist[2];   // b[n] = b[n-5] ^ b[n-3]
      z    = !(m_hist[0] | m_hist[1] | m_hist[2] | m_hist[3] | m_hist[4]);
      skip = 0;
`ifdef PRBS_STUCK_DET_EN
      if (d) m_stuck = 0;
`else
      z = 0;
`endif
      case (m_mode)
        0: begin
          hist_push(d);
          m_fill++;
          if (m_fill == 5) begin m_fill = 0; m_mode = 1; m_run = 0; end
        end
        1: begin
          hist_push(d);
          if (z && !d) begin m_run = 0; m_stuck = 1; skip = 1; end
          if (!skip) begin
            if (d == p) begin
              m_run++;
              if (m_run == LOCK) begin m_mode = 2; m_run = 0; m_pos = 0; m_werr = 0; end
            end else m_run = 0;
          end
        end
        default: begin
          if (z) begin
            m_mode = 0; m_fill = 0;
          end else begin
            wrap  = (m_pos == 30);
            m_pos = wrap ? 0 : m_pos + 1;
            if (d != p) begin
              m_pulse = 1;
              if (m_cnt < 65535) m_cnt++;
              if (m_cnt_sat < 15) m_cnt_sat++;
              m_werr++;
            end
            if (m_werr == THRESH) begin
              m_mode = 0; m_fill = 0; m_werr = 0;
            end else begin
              hist_push(p);
              if (wrap) m_werr = 0;
            end
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    check("locked",    {31'd0, locked},    {31'd0, m_mode == 2});
    check("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
    check("err_count", {16'd0, err_count}, m_cnt);
    check("stuck",     {31'd0, stuck},     {31'd0, m_stuck});
    check("sat_count", {28'd0, s_err_count}, m_cnt_sat);
  endtask

  // one clock: drive inputs, advance the model at the edge, compare just after
  task automatic step(input bit v, input bit d, input bit c);
    din_valid = v; din = d; clear = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int lock_at, pulses, vcnt, idx;
    bit lost, lk105, lk106, v, e, c;

    g[0] = 0;
    {g[1], g[2], g[3], g[4], g[5]} = 5'b10101;
    for (int n = 6; n < 1200; n++) g[n] = g[n-5] ^ g[n-3];

    // reset state
    do_reset();
    check("reset_locked", {31'd0, locked}, 32'd0);
    check("reset_count",  {16'd0, err_count}, 32'd0);

    // clean lock: locked rises one clock after bit 13, no errors in 200 bits
    lock_at = 0;
    for (int n = 1; n <= 200; n++) begin
      step(1, g[n], 0);
      if (locked && lock_at == 0) lock_at = n;
    end
    check("clean_lock_point", lock_at, 32'd13);
    check("clean_err_count", {16'd0, err_count}, 32'd0);

    // single errors at bits 40 and 70
    do_reset();
    pulses = 0; lost = 0;
    for (int n = 1; n <= 120; n++) begin
      step(1, g[n] ^ (n == 40 || n == 70), 0);
      if (err_pulse) pulses++;
      if (n > 13 && !locked) lost = 1;
    end
    check("single_pulses", pulses, 32'd2);
    check("single_count", {16'd0, err_count}, 32'd2);
    check("single_kept_lock", {31'd0, lost}, 32'd0);

    // loss of lock: 4 errors in one window, then relock after 13 clean bits
    do_reset();
    lock_at = 0;
    for (int n = 1; n <= 60; n++) begin
      step(1, g[n] ^ (n inside {30, 32, 34, 36}), 0);
      if (n == 35) check("lol_before", {31'd0, locked}, 32'd1);
      if (n == 36) check("lol_after",  {31'd0, locked}, 32'd0);
      if (n > 36 && locked && lock_at == 0) lock_at = n;
    end
    check("relock_point", lock_at, 32'd49);

    // window boundary: windows are bits 14-44, 45-75, 76-106
    do_reset();
    lk105 = 0; lk106 = 1;
    for (int n = 1; n <= 110; n++) begin
      step(1, g[n] ^ (n inside {20, 25, 30, 50, 55, 60, 80, 90, 100, 106}), 0);
      if (n == 105) lk105 = locked;
      if (n == 106) lk106 = locked;
    end
    check("window_kept", {31'd0, lk105}, 32'd1);
    check("window_wrap_loss", {31'd0, lk106}, 32'd0);

    // clear together with an error gives a count of exactly one
    do_reset();
    for (int n = 1; n <= 59; n++) step(1, g[n] ^ (n == 20 || n == 40), 0);
    check("pre_clear_count", {16'd0, err_count}, 32'd2);
    step(1, ~g[60], 1);
    check("clear_plus_err", {16'd0, err_count}, 32'd1);

    // saturation: 20 errors spaced 11 bits apart never reach 4 per window
    do_reset();
    for (int n = 1; n <= 235; n++) step(1, g[n] ^ (n >= 20 && n <= 229 && (n - 20) % 11 == 0), 0);
    check("sat_main_count", {16'd0, err_count}, 32'd20);
    check("sat_narrow_count", {28'd0, s_err_count}, 32'd15);
    check("sat_still_locked", {31'd0, locked}, 32'd1);

    // reset mid-VERIFY after errors and a loss of lock
    do_reset();
    for (int n = 1; n <= 28; n++) step(1, g[n] ^ (n inside {15, 17, 19, 21}), 0);
    check("pre_reset_count", {16'd0, err_count}, 32'd4);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("midreset_count", {16'd0, err_count}, 32'd0);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    lock_at = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1, g[n], 0);
      if (locked && lock_at == 0) lock_at = n;
    end
    check("rehunt_lock_point", lock_at, 32'd13);

    // stuck-at-zero stream
    do_reset();
    lock_at = 0;
    for (int n = 1; n <= 500; n++) begin
      step(1, 0, 0);
      if (locked && lock_at == 0) lock_at = n;
    end
`ifdef PRBS_STUCK_DET_EN
    check("stuck_flag", {31'd0, stuck}, 32'd1);
    check("stuck_no_lock", {31'd0, locked}, 32'd0);
`else
    check("zero_lock_point", lock_at, 32'd13);
    check("zero_stuck_tied", {31'd0, stuck}, 32'd0);
`endif

    // gapped valid: lock point counted in valid bits is unchanged
    do_reset();
    vcnt = 0; lock_at = 0;
    for (int i = 0; i < 200 && lock_at == 0; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        vcnt++;
        step(1, g[vcnt], 0);
      end else begin
        step(0, 1'($urandom), 0);
      end
      if (locked) lock_at = vcnt;
    end
    check("gapped_lock_point", lock_at, 32'd13);

    // random valid gaps, sparse errors and clears against the model
    idx = vcnt;
    for (int i = 0; i < 600; i++) begin
      v = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 24) == 0);
      if (v) begin
        idx++;
        step(1, g[idx] ^ e, c);
      end else begin
        step(0, 1'($urandom), c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
